// File: rtl/taxi_fare_calc.sv
// taxi_fare_calc
// Fare and trip-state engine for the taxi meter. It receives debounced
// one-cycle strobes for wheel pulses and key presses. It tracks the trip
// state (idle / waiting / driving), the trip distance in 100 m units, the
// accumulated waiting time and the running fare in 0.1-yuan units.
//
// Ports
//   sys_clk     in   system clock, the only clock
//   sys_rst     in   asynchronous active-high reset
//   pulse_evt   in   one-cycle strobe per debounced wheel pulse
//   stat_key    in   one-cycle strobe per debounced state-key press
//   trip_end    in   one-cycle strobe ending the trip
//   drive_stat  out  trip state: 0 = IDLE, 1 = WAIT, 2 = DRIVE
//   dist_100m   out  trip distance in 100 m units, clamps at FARE_MAX
//   wait_sec    out  total waiting seconds in the trip, clamps at 16'hFFFF
//   fare        out  current fare in 0.1-yuan units, clamps at FARE_MAX
//   fare_upd    out  one-cycle strobe in the cycle where a new fare value appears
module taxi_fare_calc #(
  parameter int PULSE_PER_100M    = 50,
  parameter int CLK_PER_SEC       = 50_000_000,
  parameter int BASE_FARE         = 100,
  parameter int BASE_DIST         = 30,
  parameter int DIST_RATE         = 2,
  parameter int WAIT_SEC_PER_UNIT = 60,
  parameter int WAIT_RATE         = 5,
  parameter int FARE_MAX          = 9999
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        pulse_evt,
  input  logic        stat_key,
  input  logic        trip_end,
  output logic [1:0]  drive_stat,
  output logic [15:0] dist_100m,
  output logic [15:0] wait_sec,
  output logic [15:0] fare,
  output logic        fare_upd
);

  localparam int DIV_W  = (PULSE_PER_100M > 1) ? $clog2(PULSE_PER_100M) : 1;
  localparam int PRE_W  = (CLK_PER_SEC > 1) ? $clog2(CLK_PER_SEC) : 1;
  localparam int UNIT_W = $clog2(WAIT_SEC_PER_UNIT + 1);

  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(PULSE_PER_100M - 1);
  localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(CLK_PER_SEC - 1);
  localparam logic [UNIT_W-1:0] UNIT_LAST = UNIT_W'(WAIT_SEC_PER_UNIT - 1);

  localparam logic [15:0] MAX16   = 16'(FARE_MAX);
  localparam logic [15:0] BASE16  = 16'(BASE_FARE);
  localparam logic [15:0] BDIST16 = 16'(BASE_DIST);
  localparam logic [15:0] DRATE16 = 16'(DIST_RATE);
  localparam logic [15:0] WRATE16 = 16'(WAIT_RATE);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    DRIVE = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [DIV_W-1:0]  div_cnt, div_nxt;
  logic [PRE_W-1:0]  pre_cnt, pre_nxt;
  logic [UNIT_W-1:0] unit_cnt, unit_nxt;
  logic [15:0]       dist_nxt, wait_nxt, fare_nxt;

  // Saturating add. The headroom is checked before adding so the 16-bit sum
  // can never wrap past FARE_MAX.
  function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [15:0] b);
    if (a > (MAX16 - b)) return MAX16;
    return a + b;
  endfunction

  // Next-state and datapath logic. The pulse and prescaler work is decided
  // by the state before any key/trip_end transition in the same cycle. This
  // is why a pulse arriving with the DRIVE->WAIT key still counts.
  always_comb begin
    state_nxt = state;
    div_nxt   = div_cnt;
    pre_nxt   = pre_cnt;
    unit_nxt  = unit_cnt;
    dist_nxt  = dist_100m;
    wait_nxt  = wait_sec;
    fare_nxt  = fare;

    case (state)
      IDLE: begin
        // trip_end has no meaning here; a key press starts a fresh trip
        if (stat_key) begin
          state_nxt = DRIVE;
          fare_nxt  = BASE16;
          dist_nxt  = '0;
          wait_nxt  = '0;
          div_nxt   = '0;
          pre_nxt   = '0;
          unit_nxt  = '0;
        end
      end

      DRIVE: begin
        if (pulse_evt) begin
          if (div_cnt == DIV_LAST) begin
            div_nxt  = '0;
            dist_nxt = (dist_100m >= MAX16) ? MAX16 : dist_100m + 16'd1;
            if (dist_nxt > BDIST16) fare_nxt = sat_add(fare, DRATE16);
          end else begin
            div_nxt = div_cnt + 1'b1;
          end
        end
        if (trip_end) begin
          state_nxt = IDLE;
        end else if (stat_key) begin
          state_nxt = WAIT;
          pre_nxt   = '0;
        end
      end

      WAIT: begin
        if (pre_cnt == PRE_LAST) begin
          pre_nxt  = '0;
          wait_nxt = (wait_sec == 16'hFFFF) ? wait_sec : wait_sec + 16'd1;
          if (unit_cnt == UNIT_LAST) begin
            unit_nxt = '0;
            fare_nxt = sat_add(fare, WRATE16);
          end else begin
            unit_nxt = unit_cnt + 1'b1;
          end
        end else begin
          pre_nxt = pre_cnt + 1'b1;
        end
        if (trip_end) begin
          state_nxt = IDLE;
        end else if (stat_key) begin
          state_nxt = DRIVE;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  // State and output registers. fare_upd marks the cycle in which a fare
  // value that differs from the previous one first appears on the output.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state     <= IDLE;
      div_cnt   <= '0;
      pre_cnt   <= '0;
      unit_cnt  <= '0;
      dist_100m <= '0;
      wait_sec  <= '0;
      fare      <= '0;
      fare_upd  <= 1'b0;
    end else begin
      state     <= state_nxt;
      div_cnt   <= div_nxt;
      pre_cnt   <= pre_nxt;
      unit_cnt  <= unit_nxt;
      dist_100m <= dist_nxt;
      wait_sec  <= wait_nxt;
      fare      <= fare_nxt;
      fare_upd  <= (fare_nxt != fare);
    end
  end

  assign drive_stat = state;

endmodule

// File: tb/tb_taxi_fare_calc.sv
// tb_taxi_fare_calc
// Testbench for taxi_fare_calc using small meter parameters.
// It first runs a directed trip scenario and then a randomized stretch.
// The reference model does not copy the RTL counters. It keeps only the
// total number of pulses driven in the trip, the seconds completed in earlier
// waiting spells and the clock count of the current waiting spell. Distance,
// waiting time and fare are computed from these totals with plain arithmetic.
module tb_taxi_fare_calc;

  localparam int P   = 4;
  localparam int C   = 10;
  localparam int BF  = 100;
  localparam int BD  = 2;
  localparam int DR  = 2;
  localparam int W   = 3;
  localparam int WR  = 5;
  localparam int MAX = 120;

  logic        sys_clk;
  logic        sys_rst;
  logic        pulse_evt;
  logic        stat_key;
  logic        trip_end;
  logic [1:0]  drive_stat;
  logic [15:0] dist_100m;
  logic [15:0] wait_sec;
  logic [15:0] fare;
  logic        fare_upd;

  int total = 0;
  int bad   = 0;

  // reference model state
  int m_state;
  bit m_started;
  int m_pulses;
  int m_sec_done;
  int m_ep_cyc;
  bit m_upd;

  taxi_fare_calc #(
    .PULSE_PER_100M(P), .CLK_PER_SEC(C), .BASE_FARE(BF), .BASE_DIST(BD),
    .DIST_RATE(DR), .WAIT_SEC_PER_UNIT(W), .WAIT_RATE(WR), .FARE_MAX(MAX)
  ) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .pulse_evt(pulse_evt),
    .stat_key(stat_key), .trip_end(trip_end), .drive_stat(drive_stat),
    .dist_100m(dist_100m), .wait_sec(wait_sec), .fare(fare), .fare_upd(fare_upd)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  function automatic int e_dist();
    int d;
    d = m_pulses / P;
    return (d > MAX) ? MAX : d;
  endfunction

  function automatic int e_wsec();
    int s;
    s = m_sec_done + ((m_state == 1) ? (m_ep_cyc / C) : 0);
    return (s > 65535) ? 65535 : s;
  endfunction

  function automatic int e_fare();
    int charged_dist;
    int f;
    if (!m_started) return 0;
    charged_dist = (m_pulses / P) - BD;
    if (charged_dist < 0) charged_dist = 0;
    f = BF + DR * charged_dist + WR * (e_wsec() / W);
    return (f > MAX) ? MAX : f;
  endfunction

  task automatic modelReset();
    m_state    = 0;
    m_started  = 1'b0;
    m_pulses   = 0;
    m_sec_done = 0;
    m_ep_cyc   = 0;
    m_upd      = 1'b0;
  endtask

  task automatic foldWait();
    m_sec_done = m_sec_done + m_ep_cyc / C;
    m_ep_cyc   = 0;
  endtask

  // One clock of trip behaviour. Activity is judged against the state before
  // the key or trip_end acts, and trip_end overrides a key outside IDLE.
  task automatic modelStep(input bit p, input bit k, input bit e);
    int s;
    s = m_state;
    if (s == 2 && p) m_pulses++;
    if (s == 1) m_ep_cyc++;
    if (s == 0) begin
      if (k) begin
        m_started  = 1'b1;
        m_pulses   = 0;
        m_sec_done = 0;
        m_ep_cyc   = 0;
        m_state    = 2;
      end
    end else if (e) begin
      if (s == 1) foldWait();
      m_state = 0;
    end else if (k) begin
      if (s == 2) begin
        m_ep_cyc = 0;
        m_state  = 1;
      end else begin
        foldWait();
        m_state = 2;
      end
    end
  endtask

  task automatic checkVal(input string tag, input string name,
                          input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s %s observed=%0d expected=%0d", tag, name, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag);
    checkVal(tag, "drive_stat", 16'(drive_stat), 16'(m_state));
    checkVal(tag, "dist_100m", dist_100m, 16'(e_dist()));
    checkVal(tag, "wait_sec", wait_sec, 16'(e_wsec()));
    checkVal(tag, "fare", fare, 16'(e_fare()));
    checkVal(tag, "fare_upd", 16'(fare_upd), 16'(m_upd));
  endtask

  // Drive one cycle of strobes and move the model across the same edge.
  // Then sample 1 ns after the edge and compare against the model.
  task automatic applyStimulus(input bit p, input bit k, input bit e, input string tag);
    int prev;
    pulse_evt = p;
    stat_key  = k;
    trip_end  = e;
    prev = e_fare();
    @(posedge sys_clk);
    modelStep(p, k, e);
    m_upd = (e_fare() != prev);
    #1;
    pulse_evt = 1'b0;
    stat_key  = 1'b0;
    trip_end  = 1'b0;
    checkOutput(tag);
  endtask

  // Assert the reset between clock edges. Check that it takes effect without
  // waiting for a clock edge, then release it before the next edge.
  task automatic doReset(input string tag);
    sys_rst = 1'b1;
    #2;
    modelReset();
    checkOutput(tag);
    checkVal(tag, "fare_zero", fare, 16'd0);
    checkVal(tag, "state_zero", 16'(drive_stat), 16'd0);
    #1;
    sys_rst = 1'b0;
  endtask

  initial begin
    int upd_cnt;
    int d0;
    int i;
    sys_rst   = 1'b1;
    pulse_evt = 1'b0;
    stat_key  = 1'b0;
    trip_end  = 1'b0;
    modelReset();
    repeat (2) @(posedge sys_clk);
    #1;
    checkOutput("reset");
    sys_rst = 1'b0;

    // 1: trip start
    applyStimulus(0, 1, 0, "start");
    checkVal("start", "state_const", 16'(drive_stat), 16'd2);
    checkVal("start", "fare_const", fare, 16'd100);
    checkVal("start", "upd_const", 16'(fare_upd), 16'd1);
    applyStimulus(0, 0, 0, "start_hold");

    // 2: 12 pulses give 300 m and one distance charge
    upd_cnt = 0;
    for (int n = 0; n < 12; n++) begin
      applyStimulus(1, 0, 0, "drive");
      upd_cnt += int'(fare_upd);
    end
    checkVal("drive", "dist_const", dist_100m, 16'd3);
    checkVal("drive", "fare_const", fare, 16'd102);
    checkVal("drive", "upd_count", 16'(upd_cnt), 16'd1);

    // 3: 30 clocks of waiting give three seconds and one wait charge
    applyStimulus(0, 1, 0, "to_wait");
    for (int n = 0; n < 30; n++) applyStimulus(0, 0, 0, "waiting");
    checkVal("waiting", "wsec_const", wait_sec, 16'd3);
    checkVal("waiting", "fare_const", fare, 16'd107);
    applyStimulus(1, 0, 0, "wait_pulse");
    checkVal("wait_pulse", "dist_const", dist_100m, 16'd3);

    // 4: a pulse that arrives with the key still counts in DRIVE
    applyStimulus(0, 1, 0, "to_drive");
    for (int n = 0; n < 3; n++) applyStimulus(1, 0, 0, "pre_pulse");
    applyStimulus(1, 1, 0, "pulse_key");
    checkVal("pulse_key", "dist_const", dist_100m, 16'd4);
    checkVal("pulse_key", "state_const", 16'(drive_stat), 16'd1);

    // 5: drive until the fare clamps at its maximum
    applyStimulus(0, 1, 0, "to_drive2");
    i = 0;
    while (i < 100 && e_fare() != MAX) begin
      applyStimulus(1, 0, 0, "climb");
      i++;
    end
    checkVal("climb", "fare_max", fare, 16'd120);
    d0 = e_dist();
    upd_cnt = 0;
    for (int n = 0; n < 8; n++) begin
      applyStimulus(1, 0, 0, "sat");
      upd_cnt += int'(fare_upd);
    end
    checkVal("sat", "fare_const", fare, 16'd120);
    checkVal("sat", "dist_grow", dist_100m, 16'(d0 + 2));
    checkVal("sat", "upd_count", 16'(upd_cnt), 16'd0);

    // 6: trip_end wins over the key; the next trip starts clean; reset mid-trip
    applyStimulus(0, 1, 1, "end_key");
    checkVal("end_key", "state_const", 16'(drive_stat), 16'd0);
    checkVal("end_key", "fare_held", fare, 16'd120);
    applyStimulus(0, 1, 0, "restart");
    checkVal("restart", "dist_const", dist_100m, 16'd0);
    checkVal("restart", "fare_const", fare, 16'd100);
    for (int n = 0; n < 5; n++) applyStimulus(1, 0, 0, "mid_trip");
    doReset("mid_reset");

    // randomized stretch
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 199) == 0) begin
        doReset("rand_reset");
      end else begin
        applyStimulus(1'($urandom_range(0, 1)),
                      ($urandom_range(0, 11) == 0),
                      ($urandom_range(0, 39) == 0),
                      "random");
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/taxi_fare_calc.md
# taxi_fare_calc

Fare and trip-state engine for the taxi meter. Sits directly downstream of the wheel-pulse debounce stage and consumes its one-cycle debounced pulse strobe plus a debounced state-key strobe. Keeps the trip state machine (idle / waiting / driving), accumulates distance in 100 m units and waiting time, and maintains the running fare in 0.1-yuan units for the display stage.

## Interface
- PULSE_PER_100M, 50: debounced wheel pulses per 100 m.
- CLK_PER_SEC, 50_000_000: sys_clk cycles per second.
- BASE_FARE, 100: starting fare, 0.1-yuan units (10.0 yuan).
- BASE_DIST, 30: distance included in base fare, 100 m units.
- DIST_RATE, 2: fare added per 100 m beyond BASE_DIST.
- WAIT_SEC_PER_UNIT, 60: waiting seconds per wait charge.
- WAIT_RATE, 5: fare added per completed wait unit.
- FARE_MAX, 9999: saturation limit for fare and dist_100m.
- sys_clk  in  1  system clock; the only clock.
- sys_rst  in  1  reset, asynchronous, active-high.
- pulse_evt  in  1  one-cycle strobe per debounced wheel pulse, sys_clk-synchronous.
- stat_key  in  1  one-cycle strobe per debounced state-key press.
- trip_end  in  1  one-cycle strobe ending the trip.
- drive_stat  out  2  0 = IDLE, 1 = WAIT, 2 = DRIVE; 3 never driven.
- dist_100m  out  16  trip distance, 100 m units.
- wait_sec  out  16  total waiting seconds in the trip, saturating at 16'hFFFF.
- fare  out  16  current fare, 0.1-yuan units.
- fare_upd  out  1  one-cycle strobe in the cycle after fare changes value.

## Operation
- All outputs are registered. Reset values are drive_stat = 0, dist_100m = 0, wait_sec = 0, fare = 0, fare_upd = 0. All internal counters reset to 0.
- State transitions use stat_key:
  - IDLE -> DRIVE starts a trip. It loads fare = BASE_FARE and clears dist_100m, wait_sec, pulse divider, second prescaler and wait-unit counter. fare_upd pulses.
  - DRIVE -> WAIT.
  - WAIT -> DRIVE.
- trip_end in WAIT or DRIVE moves to IDLE. fare, dist_100m and wait_sec hold their values until the next trip start. trip_end in IDLE is ignored.
- If trip_end and stat_key arrive in the same cycle, trip_end wins.
- Distance:
  - In DRIVE, each pulse_evt increments the pulse divider (0..PULSE_PER_100M-1).
  - On wrap, dist_100m increments.
  - If the new dist_100m > BASE_DIST, fare += DIST_RATE.
  - pulse_evt is ignored in IDLE and WAIT.
  - The divider keeps its partial count across DRIVE<->WAIT.
- Waiting time:
  - In WAIT, the prescaler counts sys_clk cycles 0..CLK_PER_SEC-1. On wrap, wait_sec increments and the wait-unit counter increments.
  - When the wait-unit counter reaches WAIT_SEC_PER_UNIT, it clears to 0 and fare += WAIT_RATE.
  - The prescaler clears on every entry to WAIT. The wait-unit counter keeps its partial count.
- Saturation:
  - fare and dist_100m clamp at FARE_MAX. An addition that would exceed FARE_MAX yields FARE_MAX.
  - fare_upd pulses only if the stored value actually changed.
- Simultaneous events:
  - pulse_evt and stat_key in the same cycle: the pulse is evaluated against the pre-transition state.
  - So DRIVE + pulse + key counts the pulse, and WAIT + pulse + key ignores it.
  - Fare increments within one cycle are mutually exclusive by state, so no double-add case exists.

## Timing
- Strobe at edge n: the state, counter and fare update is visible after edge n. fare_upd is high for cycle n+1 only.
- Latency from the completing pulse_evt to the new dist_100m/fare is 1 cycle.
- Minimum stat_key spacing: 1 cycle. Back-to-back keys each cause a transition.
- Asserting sys_rst at any point, including mid-trip, immediately forces all reset values. There is no resume after reset.
- Arithmetic is unsigned 16-bit, with compare-before-add for saturation.

## Test plan
Simulation parameters: PULSE_PER_100M = 4, CLK_PER_SEC = 10, BASE_DIST = 2, WAIT_SEC_PER_UNIT = 3, BASE_FARE = 100, DIST_RATE = 2, WAIT_RATE = 5, FARE_MAX = 120.

1. Reset, then stat_key. Expect drive_stat = 2, fare = 100, and fare_upd high for 1 cycle.
2. Drive distance: in DRIVE, apply 12 pulse_evt. Expect dist_100m = 3 and fare = 102. fare_upd fires once, after the 12th pulse.
3. Wait charge: stat_key to WAIT, then hold 30 clocks. Expect wait_sec = 3 and fare = 107. Apply pulse_evt during WAIT; expect dist_100m unchanged.
4. Simultaneous key and pulse: in DRIVE, pulse 3 times, then a 4th pulse together with stat_key. Expect dist_100m to increment and drive_stat = 1.
5. Saturation: drive until fare reaches 120, then apply 8 more pulses. Expect fare = 120, dist_100m still increasing, and no fare_upd.
6. Trip end and reset: trip_end together with stat_key. Expect drive_stat = 0 and fare held. Next stat_key clears dist_100m and sets fare = 100. Assert sys_rst mid-trip; expect all outputs 0 immediately.
